rf_wb_arbiter: RTL and testbench



---
 rtl/rf_wb_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter for the register file's single write port.
// Each functional-unit lane pushes {addr,data} results into its own small FIFO.
// Every cycle one non-empty FIFO is selected and its head is popped into a
// selection register. The next edge copies that register onto the registered
// wr_en/wr_addr/wr_data/grant_lane outputs. An accepted entry therefore
// reaches wr_en two edges after it is accepted.
//
// Build option: define RF_WB_FIXED_PRIO_EN to use fixed priority, where the
// lowest-numbered non-empty lane always wins. Leave it undefined (the default)
// to use round-robin selection with a rotating start pointer.
//
// Handshake: a lane transfer happens on a rising edge where
// lane_valid[i] & lane_ready[i] is high. lane_ready[i] depends only on the
// FIFO being not full and rst being low, and never on lane_valid[i]. A full
// FIFO keeps lane_ready low even in a cycle where it is popped. The write port
// has no back-pressure, so a grant always completes.

module rf_wb_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0]            lane_valid,
  output logic [NUM_LANES-1:0]            lane_ready,
  input  logic [NUM_LANES*ADDR_W-1:0]     lane_addr,
  input  logic [NUM_LANES*DATA_W-1:0]     lane_data,
  output logic                            wr_en,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [DATA_W-1:0]               wr_data,
  output logic [$clog2(NUM_LANES)-1:0]    grant_lane,
  output logic                            pending
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Per-lane FIFO storage and bookkeeping. The occupancy count resolves
  // full and empty, so the pointers simply wrap modulo FIFO_DEPTH.
  logic [ADDR_W-1:0] addr_mem_q [NUM_LANES][FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [NUM_LANES][FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q   [NUM_LANES];
  logic [PW-1:0]     wr_ptr_q   [NUM_LANES];
  logic [CW-1:0]     count_q    [NUM_LANES];

  logic [NUM_LANES-1:0] full;
  logic [NUM_LANES-1:0] nonempty;
  logic [NUM_LANES-1:0] push;
  logic [NUM_LANES-1:0] pop;

  // Arbitration result for the current cycle.
  logic              gnt_found;
  logic [LW-1:0]     gnt_lane;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Selection register between the FIFO pop and the write port.
  logic              sel_valid_q;
  logic [LW-1:0]     sel_lane_q;
  logic [ADDR_W-1:0] sel_addr_q;
  logic [DATA_W-1:0] sel_data_q;

  // Registered write port.
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [LW-1:0]     grant_lane_q;

`ifndef RF_WB_FIXED_PRIO_EN
  // Round-robin start pointer: the lane searched first this cycle.
  logic [LW-1:0] rr_q;
  logic [LW-1:0] rr_d;
`endif

  // Per-lane status flags derived from the occupancy counts.
  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      full[i]     = (count_q[i] == CW'(FIFO_DEPTH));
      nonempty[i] = (count_q[i] != '0);
    end
  end

  assign lane_ready = ~full & {NUM_LANES{~rst}};
  assign push       = lane_valid & lane_ready;

`ifdef RF_WB_FIXED_PRIO_EN
  // Fixed priority: the lowest-numbered non-empty lane wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_lane  = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (nonempty[k]) begin
        gnt_found = 1'b1;
        gnt_lane  = k[LW-1:0];
      end
    end
  end
`else
  // Round-robin: search rr_q, rr_q+1, ... and wrap modulo NUM_LANES.
  always_comb begin
    logic [LW-1:0] cand;
    gnt_found = 1'b0;
    gnt_lane  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = rr_q + k[LW-1:0];
      if (!gnt_found && nonempty[cand]) begin
        gnt_found = 1'b1;
        gnt_lane  = cand;
      end
    end
  end

  // The pointer moves past the granted lane and holds when nothing is granted.
  always_comb begin
    rr_d = rr_q;
    if (gnt_found) begin
      rr_d = gnt_lane + LW'(1);
    end
  end
`endif

  // Decode the grant into a per-lane pop strobe and read the winning head.
  always_comb begin
    pop = '0;
    if (gnt_found && !rst) begin
      pop[gnt_lane] = 1'b1;
    end
    gnt_addr = addr_mem_q[gnt_lane][rd_ptr_q[gnt_lane]];
    gnt_data = data_mem_q[gnt_lane][rd_ptr_q[gnt_lane]];
  end

  // FIFO storage writes. The contents need no reset because the counts gate them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push[i]) begin
        addr_mem_q[i][wr_ptr_q[i]] <= lane_addr[i*ADDR_W +: ADDR_W];
        data_mem_q[i][wr_ptr_q[i]] <= lane_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers and counts. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rst) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end else begin
        if (push[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + CW'(1);
          2'b01:   count_q[i] <= count_q[i] - CW'(1);
          default: count_q[i] <= count_q[i];
        endcase
      end
    end
  end

`ifndef RF_WB_FIXED_PRIO_EN
  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Selection stage: capture the popped head together with its lane number.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_valid_q <= 1'b0;
      sel_lane_q  <= '0;
      sel_addr_q  <= '0;
      sel_data_q  <= '0;
    end else begin
      sel_valid_q <= gnt_found;
      if (gnt_found) begin
        sel_lane_q <= gnt_lane;
        sel_addr_q <= gnt_addr;
        sel_data_q <= gnt_data;
      end
    end
  end

  // Write-port stage: the address, data and lane hold their values while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      grant_lane_q <= '0;
    end else begin
      wr_en_q <= sel_valid_q;
      if (sel_valid_q) begin
        wr_addr_q    <= sel_addr_q;
        wr_data_q    <= sel_data_q;
        grant_lane_q <= sel_lane_q;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign grant_lane = grant_lane_q;

  // Work is outstanding while any entry sits in a FIFO, in the selection
  // register, or on the write port. It is forced low during reset.
  assign pending = ~rst & ((|nonempty) | sel_valid_q | wr_en_q);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: table vectors, hand-written corner sequences and random
// traffic for rf_wb_arbiter. A queue-level reference model predicts every
// output after every edge.
module tb_rf_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int D  = 2;
  localparam int LW = 2;
  localparam int EW = AW + DW;

  // Clock and DUT signals.
  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    lane_valid;
  logic [N-1:0]    lane_ready;
  logic [N*AW-1:0] lane_addr;
  logic [N*DW-1:0] lane_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [LW-1:0]   grant_lane;
  logic            pending;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .NUM_LANES(N), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .lane_valid(lane_valid), .lane_ready(lane_ready),
    .lane_addr(lane_addr), .lane_data(lane_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant_lane(grant_lane), .pending(pending)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: each lane is an array that shifts down on a pop, plus
  // the selection beat and the write-port beat.
  logic [EW-1:0] m_ent [N][D];
  int            m_cnt [N];
  int            m_rr  = 0;
  bit            s1v   = 0;
  int            s1_lane = 0;
  logic [EW-1:0] s1_ent = '0;
  bit            o_en  = 0;
  int            o_lane = 0;
  logic [EW-1:0] o_ent = '0;

  // Scoreboard for in-order checks on one lane.
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge, using the inputs that are applied now.
  task automatic model_edge();
    bit [N-1:0] rdy;
    bit found;
    int g;
    int l;
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr = 0; s1v = 0; s1_lane = 0; s1_ent = '0;
      o_en = 0; o_lane = 0; o_ent = '0;
    end else begin
      for (int i = 0; i < N; i++) rdy[i] = (m_cnt[i] < D);
      o_en = s1v;
      if (s1v) begin
        o_lane = s1_lane;
        o_ent  = s1_ent;
      end
      found = 0;
      g = 0;
`ifdef RF_WB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++) begin
        if (!found && m_cnt[k] > 0) begin found = 1; g = k; end
      end
`else
      for (int k = 0; k < N; k++) begin
        l = (m_rr + k) % N;
        if (!found && m_cnt[l] > 0) begin found = 1; g = l; end
      end
`endif
      s1v = found;
      if (found) begin
        s1_lane = g;
        s1_ent  = m_ent[g][0];
        for (int j = 0; j < D - 1; j++) m_ent[g][j] = m_ent[g][j+1];
        m_cnt[g]--;
        m_rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (lane_valid[i] && rdy[i]) begin
          m_ent[i][m_cnt[i]] = {lane_addr[i*AW +: AW], lane_data[i*DW +: DW]};
          m_cnt[i]++;
        end
      end
    end
  endtask

  // One clock: the edge, the model update, then a comparison of every output.
  task automatic tick();
    logic [N-1:0] er;
    bit ep;
    @(posedge clk);
    model_edge();
    #1;
    ep = 0;
    for (int i = 0; i < N; i++) begin
      er[i] = !rst && (m_cnt[i] < D);
      if (m_cnt[i] > 0) ep = 1;
    end
    ep = !rst && (ep || s1v || o_en);
    chk("wr_en", 64'(wr_en), 64'(o_en));
    chk("wr_addr", 64'(wr_addr), 64'(o_ent[DW +: AW]));
    chk("wr_data", 64'(wr_data), 64'(o_ent[DW-1:0]));
    chk("grant_lane", 64'(grant_lane), 64'(o_lane));
    chk("lane_ready", 64'(lane_ready), 64'(er));
    chk("pending", 64'(pending), 64'(ep));
  endtask

  task automatic set_lane(input int l, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    lane_valid[l] = v;
    lane_addr[l*AW +: AW] = a;
    lane_data[l*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lane_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  // Table vectors: the inputs applied before an edge and the outputs expected after it.
  typedef struct {
    logic         rst;
    logic [3:0]   valid;
    logic [11:0]  addr;
    logic [127:0] data;
    logic         en;
    logic [2:0]   ea;
    logic [31:0]  ed;
    logic [1:0]   eg;
    logic [3:0]   er;
    logic         ep;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [11:0] a,
                              input logic [127:0] d, input logic en, input logic [2:0] ea,
                              input logic [31:0] ed, input logic [1:0] eg,
                              input logic [3:0] er, input logic ep);
    vec_t t;
    t.rst = r; t.valid = v; t.addr = a; t.data = d;
    t.en = en; t.ea = ea; t.ed = ed; t.eg = eg; t.er = er; t.ep = ep;
    return t;
  endfunction

  vec_t vec [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen3;
    int acc1;
    int nwr;
    bit pre_acc;
    logic [EW-1:0] got;
    logic [EW-1:0] want;

    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    rst = 1'b1;
    lane_valid = '0;
    lane_addr = '0;
    lane_data = '0;

    // A single write on lane 2, then four lanes released together after a reset.
    vec[0]  = mk(1, 4'h0, 12'o0000, 128'h0, 0, 0, 32'h0, 0, 4'h0, 0);
    vec[1]  = mk(0, 4'h4, 12'o0500, 128'h00000000_DEADBEEF_00000000_00000000,
                 0, 0, 32'h0, 0, 4'hF, 1);
    vec[2]  = mk(0, 4'h0, 12'o0000, 128'h0, 0, 0, 32'h0, 0, 4'hF, 1);
    vec[3]  = mk(0, 4'h0, 12'o0000, 128'h0, 1, 5, 32'hDEADBEEF, 2, 4'hF, 1);
    vec[4]  = mk(0, 4'h0, 12'o0000, 128'h0, 0, 5, 32'hDEADBEEF, 2, 4'hF, 0);
    vec[5]  = mk(1, 4'h0, 12'o0000, 128'h0, 0, 0, 32'h0, 0, 4'h0, 0);
    vec[6]  = mk(0, 4'hF, 12'o3210, 128'h00000013_00000012_00000011_00000010,
                 0, 0, 32'h0, 0, 4'hF, 1);
    vec[7]  = mk(0, 4'h0, 12'o0000, 128'h0, 0, 0, 32'h0, 0, 4'hF, 1);
    vec[8]  = mk(0, 4'h0, 12'o0000, 128'h0, 1, 0, 32'h10, 0, 4'hF, 1);
    vec[9]  = mk(0, 4'h0, 12'o0000, 128'h0, 1, 1, 32'h11, 1, 4'hF, 1);
    vec[10] = mk(0, 4'h0, 12'o0000, 128'h0, 1, 2, 32'h12, 2, 4'hF, 1);
    vec[11] = mk(0, 4'h0, 12'o0000, 128'h0, 1, 3, 32'h13, 3, 4'hF, 1);
    vec[12] = mk(0, 4'h0, 12'o0000, 128'h0, 0, 3, 32'h13, 3, 4'hF, 0);

    for (int i = 0; i < 13; i++) begin
      rst = vec[i].rst;
      lane_valid = vec[i].valid;
      lane_addr = vec[i].addr;
      lane_data = vec[i].data;
      tick();
      chk($sformatf("tbl%0d_wr_en", i), 64'(wr_en), 64'(vec[i].en));
      chk($sformatf("tbl%0d_wr_addr", i), 64'(wr_addr), 64'(vec[i].ea));
      chk($sformatf("tbl%0d_wr_data", i), 64'(wr_data), 64'(vec[i].ed));
      chk($sformatf("tbl%0d_grant", i), 64'(grant_lane), 64'(vec[i].eg));
      chk($sformatf("tbl%0d_ready", i), 64'(lane_ready), 64'(vec[i].er));
      chk($sformatf("tbl%0d_pending", i), 64'(pending), 64'(vec[i].ep));
    end

    // Streaming on lane 0: ready never drops and wr_en stays high after two edges.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_lane(0, 1, AW'(c), $urandom());
      tick();
      chk("stream_ready0", 64'(lane_ready[0]), 64'(1));
      if (c >= 2) chk("stream_wr_en", 64'(wr_en), 64'(1));
    end
    lane_valid = '0;
    for (int c = 0; c < 4; c++) tick();

    // Starvation contrast: lane 0 stays busy while lane 3 pushes a single entry.
    do_reset();
    seen3 = 0;
    for (int c = 0; c < 9; c++) begin
      set_lane(0, 1, AW'(c), $urandom());
      set_lane(3, c == 0, 3'd7, 32'h3333_0000);
      tick();
      if (wr_en && grant_lane == 2'd3) seen3 = 1;
    end
`ifdef RF_WB_FIXED_PRIO_EN
    chk("starve_lane3_never", 64'(seen3), 64'(0));
`else
    chk("rr_lane3_granted", 64'(seen3), 64'(1));
`endif
    lane_valid = '0;
    for (int c = 0; c < 8; c++) tick();

    // Backpressure on lane 1: three entries pushed while the other lanes compete.
    do_reset();
    acc1 = 0;
    exp_q.delete();
    for (int c = 0; c < 40; c++) begin
      for (int l = 0; l < N; l++) begin
        if (l != 1) set_lane(l, c < 4, AW'($urandom()), $urandom());
      end
      set_lane(1, acc1 < 3, AW'(acc1 + 4), 32'hB000 + acc1);
      pre_acc = lane_valid[1] && (m_cnt[1] < D);
      want = {lane_addr[1*AW +: AW], lane_data[1*DW +: DW]};
      tick();
      if (pre_acc) begin
        exp_q.push_back(want);
        acc1++;
        if (acc1 == 2) chk("bp_ready1_low", 64'(lane_ready[1]), 64'(0));
      end
      if (wr_en && grant_lane == 2'd1) begin
        got = {wr_addr, wr_data};
        if (exp_q.size() == 0) begin
          chk("bp_unexpected_write", 64'(got), 64'(0));
        end else begin
          chk("bp_order", 64'(got), 64'(exp_q.pop_front()));
        end
      end
    end
    chk("bp_all_accepted", 64'(acc1), 64'(3));
    chk("bp_all_written", 64'(exp_q.size()), 64'(0));

    // Reset mid-operation: queued entries and an in-flight write are discarded.
    do_reset();
    lane_valid = '0;
    for (int l = 1; l < N; l++) set_lane(l, 1, AW'(l), 32'hC000 + l);
    tick();
    lane_valid = '0;
    set_lane(0, 1, 3'd1, 32'hA0A0_0001);
    tick();
    set_lane(0, 1, 3'd2, 32'hA0A0_0002);
    tick();
    chk("rstmid_wr_en_before", 64'(wr_en), 64'(1));
    lane_valid = '0;
    rst = 1'b1;
    tick();
    chk("rstmid_wr_en", 64'(wr_en), 64'(0));
    chk("rstmid_ready", 64'(lane_ready), 64'(0));
    rst = 1'b0;
    nwr = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (wr_en) nwr++;
    end
    chk("rstmid_no_write", 64'(nwr), 64'(0));
    chk("rstmid_pending", 64'(pending), 64'(0));

    // Random traffic with occasional resets, then a drain.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int l = 0; l < N; l++) begin
        set_lane(l, $urandom_range(0, 99) < 40, AW'($urandom()), $urandom());
      end
      tick();
    end
    rst = 1'b0;
    lane_valid = '0;
    for (int c = 0; c < 16; c++) tick();
    chk("drain_pending", 64'(pending), 64'(0));
    chk("drain_wr_en", 64'(wr_en), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
